// File: rtl/port_fifo.sv
// ---------------------------------------------------------------------------
// port_fifo
//
// Per-port payload buffer sitting between the router switch fabric and the
// serial output port stage. The fabric pushes WIDTH-bit payload words; the
// head word is presented first-word-fall-through on `payload` while `rdy` is
// high. The port serializer drains roughly one word per 33+ cycles, so the
// buffer exists to absorb fabric bursts.
//
// Ports
//   clock        in   1        rising-edge clock
//   reset_n      in   1        asynchronous, active-low reset
//   push         in   1        write din into the tail this cycle
//   din          in   WIDTH    word to store
//   full         out  1        count == DEPTH
//   almost_full  out  1        count >= AF_LEVEL
//   payload      out  WIDTH    head word (FWFT); 0 when empty
//   rdy          out  1        FIFO non-empty
//   pop          in   1        remove the head word this cycle
//   count        out  AW+1     occupancy, 0..DEPTH
//   clr_err      in   1        clears overflow/underflow
//   overflow     out  1        sticky: push seen while full and no pop
//   underflow    out  1        sticky: pop seen while empty
//
// Handshake
//   Write side: a push is accepted on a rising edge when push=1 and either
//   full=0 or a pop is accepted on the same edge. A refused push is dropped
//   and sets overflow. Read side: rdy acts as valid and pop as the consumer's
//   take strobe. A pop is accepted on a rising edge when count != 0; a pop
//   against an empty FIFO is ignored and sets underflow. payload only changes
//   after a clock edge, so a consumer that samples it while rdy=1 and pops on
//   the following edge sees a stable word in between.
// ---------------------------------------------------------------------------
module port_fifo #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             almost_full,
  output logic [WIDTH-1:0] payload,
  output logic             rdy,
  input  logic             pop,
  output logic [AW:0]      count,
  input  logic             clr_err,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);

  // Storage is deliberately not reset; occupancy is tracked solely by count,
  // so stale contents are never visible.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          overflow_q;
  logic          underflow_q;

  logic empty;
  logic pop_acc;
  logic push_acc;
  logic overflow_evt;
  logic underflow_evt;

  // -------------------------------------------------------------------------
  // Status, all decoded from registered occupancy so there is no
  // input-to-output combinational path.
  // -------------------------------------------------------------------------
  assign empty       = (count_q == '0);
  assign full        = (count_q == DEPTH_C);
  assign almost_full = (count_q >= AF_C);
  assign rdy         = !empty;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

  // FWFT head word; forced to zero when empty so stale storage never leaks.
  assign payload = empty ? '0 : mem[rd_ptr];

  // -------------------------------------------------------------------------
  // Accept decisions
  // -------------------------------------------------------------------------
  // Pop only counts when something is stored. A push while full is still
  // accepted when a pop frees the head slot on the same edge; in that case
  // wr_ptr == rd_ptr, and the head word has already been consumed from the
  // pre-edge contents before the write lands.
  assign pop_acc       = pop && !empty;
  assign push_acc      = push && (!full || pop_acc);
  assign overflow_evt  = push && !push_acc;
  assign underflow_evt = pop && empty;

  // -------------------------------------------------------------------------
  // Storage write
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (push_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  // -------------------------------------------------------------------------
  // Pointers and occupancy. Pointers are AW bits wide, so DEPTH-1 wraps to 0
  // naturally; full/empty never look at the pointers.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_acc) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push_acc, pop_acc})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Sticky error flags. A new error on the same edge as clr_err wins, so an
  // event is never lost to a concurrent clear.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (overflow_evt) begin
        overflow_q <= 1'b1;
      end else if (clr_err) begin
        overflow_q <= 1'b0;
      end
      if (underflow_evt) begin
        underflow_q <= 1'b1;
      end else if (clr_err) begin
        underflow_q <= 1'b0;
      end
    end
  end

endmodule
